// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: Start/Ack handshake, PC init,
// per-instruction enable gating, load stall, run counters and watchdog.
module run_sequencer #(
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic        dec_load_i,
  input  logic        dec_reg_wr_i,
  input  logic        dec_mem_wr_i,
  output logic        pc_init_o,
  output logic        pc_en_o,
  output logic        reg_wr_en_o,
  output logic        mem_wr_en_o,
  output logic        load_sel_o,
  output logic        ack_o,
  output logic        timeout_o,
  output logic [15:0] cycle_ct_o,
  output logic [15:0] inst_ct_o
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EXEC,
    LDWAIT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic        to_q, to_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] cyc_inc;
  logic        retire;

  // Enables are killed while reset is high so an in-flight write never lands.
  always_comb begin
    pc_init_o   = 1'b0;
    pc_en_o     = 1'b0;
    reg_wr_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    load_sel_o  = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        INIT: pc_init_o = 1'b1;
        EXEC: begin
          if (!halt_i && !dec_load_i) begin
            pc_en_o     = 1'b1;
            reg_wr_en_o = dec_reg_wr_i;
            mem_wr_en_o = dec_mem_wr_i;
          end
        end
        LDWAIT: begin
          pc_en_o     = 1'b1;
          reg_wr_en_o = 1'b1;
          load_sel_o  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cyc_inc = cyc_q + 16'd1;
  assign retire  = (state_q == LDWAIT) ||
                   ((state_q == EXEC) && !halt_i && !dec_load_i);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    to_d    = to_q;
    cyc_d   = cyc_q;
    inst_d  = inst_q;
    if (start_i) begin
      state_d = INIT;
      ack_d   = 1'b0;
      to_d    = 1'b0;
      cyc_d   = 16'd0;
      inst_d  = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: ;
        INIT: state_d = EXEC;
        EXEC, LDWAIT: begin
          cyc_d = cyc_inc;
          if (retire) inst_d = inst_q + 16'd1;
          if (state_q == LDWAIT) state_d = EXEC;
          else if (halt_i)       state_d = DONE;
          else if (dec_load_i)   state_d = LDWAIT;
          // Watchdog overrides whatever the instruction asked for.
          if (cyc_inc == MAX_CYCLES) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
          ack_d = (state_d == DONE);
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
      cyc_q   <= 16'd0;
      inst_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
    end
  end

  assign ack_o      = ack_q;
  assign timeout_o  = to_q;
  assign cycle_ct_o = cyc_q;
  assign inst_ct_o  = inst_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed scenarios plus random programs
// checked cycle by cycle against a behavioural model.
module tb_run_sequencer;

  localparam logic [15:0] MAXC = 16'd8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        dec_load_i = 1'b0;
  logic        dec_reg_wr_i = 1'b0;
  logic        dec_mem_wr_i = 1'b0;
  logic        pc_init_o, pc_en_o, reg_wr_en_o;
  logic        mem_wr_en_o, load_sel_o;
  logic        ack_o, timeout_o;
  logic [15:0] cycle_ct_o, inst_ct_o;

  always #5 clk = ~clk;

  run_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .halt_i      (halt_i),
    .dec_load_i  (dec_load_i),
    .dec_reg_wr_i(dec_reg_wr_i),
    .dec_mem_wr_i(dec_mem_wr_i),
    .pc_init_o   (pc_init_o),
    .pc_en_o     (pc_en_o),
    .reg_wr_en_o (reg_wr_en_o),
    .mem_wr_en_o (mem_wr_en_o),
    .load_sel_o  (load_sel_o),
    .ack_o       (ack_o),
    .timeout_o   (timeout_o),
    .cycle_ct_o  (cycle_ct_o),
    .inst_ct_o   (inst_ct_o)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Program memory entry: {halt, load, regwr, memwr}
  logic [3:0] prog [64];

  typedef enum int {P_IDLE, P_INIT, P_RUN, P_LDW, P_DONE} phase_t;
  phase_t ph = P_IDLE;
  int     pc = 0;
  int     cyc = 0;
  int     ins = 0;
  bit     ack = 0;
  bit     to = 0;

  localparam logic [3:0] ALU  = 4'b0000;
  localparam logic [3:0] ALUR = 4'b0010;
  localparam logic [3:0] ALUM = 4'b0001;
  localparam logic [3:0] LD   = 4'b0110;
  localparam logic [3:0] HLT  = 4'b1000;

  task automatic clear_prog(input logic [3:0] fill);
    for (int i = 0; i < 64; i++) prog[i] = fill;
  endtask

  // One clock: drive, check at negedge, advance the model, reach edge+1.
  task automatic step(input bit rst, input bit st);
    logic [3:0] op;
    logic [4:0] ex;
    op = prog[pc % 64];
    rst_i = rst;
    start_i = st;
    {halt_i, dec_load_i, dec_reg_wr_i, dec_mem_wr_i} = op;
    ex = 5'b0;
    if (!rst) begin
      case (ph)
        P_INIT: ex = 5'b10000;
        P_RUN:  if (!op[3] && !op[2]) ex = {2'b01, op[1], op[0], 1'b0};
        P_LDW:  ex = 5'b01101;
        default: ;
      endcase
    end
    @(negedge clk);
    chk("enables", {pc_init_o, pc_en_o, reg_wr_en_o, mem_wr_en_o,
                    load_sel_o}, ex);
    chk("ack", ack_o, ack);
    chk("timeout", timeout_o, to);
    chk("cycle_ct", cycle_ct_o, cyc);
    chk("inst_ct", inst_ct_o, ins);
    if (ex[4]) pc = 0;
    else if (ex[3]) pc++;
    if (rst) begin
      ph = P_IDLE; cyc = 0; ins = 0; ack = 0; to = 0;
    end else if (st) begin
      ph = P_INIT; cyc = 0; ins = 0; ack = 0; to = 0;
    end else begin
      case (ph)
        P_INIT: ph = P_RUN;
        P_RUN, P_LDW: begin
          cyc++;
          if (ex[3]) ins++;
          if (ph == P_LDW) ph = P_RUN;
          else if (op[3]) ph = P_DONE;
          else if (op[2]) ph = P_LDW;
          if (cyc == int'(MAXC)) begin
            ph = P_DONE;
            to = 1;
          end
          ack = (ph == P_DONE);
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done();
    int n = 0;
    while (!ack && n < 40) begin
      step(0, 0);
      n++;
    end
    chk("run_budget", {31'd0, ack}, 32'd1);
  endtask

  task automatic final_counts(input string tag, input int c, input int i,
                              input bit t);
    chk({tag, "_ack"}, ack_o, 1);
    chk({tag, "_cyc"}, cycle_ct_o, c);
    chk({tag, "_inst"}, inst_ct_o, i);
    chk({tag, "_to"}, timeout_o, t);
  endtask

  task automatic load_s2();
    clear_prog(ALU);
    prog[0] = ALUR;
    prog[1] = ALUM;
    prog[2] = ALUR;
    prog[3] = 4'b1111;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout");
    $fatal(1, "stuck");
  end

  initial begin
    clear_prog(ALU);
    @(posedge clk);
    #1;
    step(1, 0);
    step(1, 0);
    chk("rst_cyc", cycle_ct_o, 0);
    chk("rst_ack", ack_o, 0);

    // ALU, ALU, ALU, Halt
    load_s2();
    step(0, 1);
    run_to_done();
    final_counts("s2", 4, 3, 0);
    step(0, 0);

    // Load, ALU, Halt
    clear_prog(ALU);
    prog[0] = LD;
    prog[1] = ALUR;
    prog[2] = HLT;
    step(0, 1);
    run_to_done();
    final_counts("s3", 4, 2, 0);

    // Runaway program hits the watchdog
    clear_prog(ALUR);
    step(0, 1);
    run_to_done();
    final_counts("s4", 8, 8, 1);

    // Restart mid-run, then rerun the first program
    step(0, 1);
    step(0, 0);
    for (int k = 0; k < 5; k++) step(0, 0);
    step(0, 1);
    chk("s5_cyc_clr", cycle_ct_o, 0);
    chk("s5_inst_clr", inst_ct_o, 0);
    chk("s5_pcinit", pc_init_o, 1);
    load_s2();
    run_to_done();
    final_counts("s5", 4, 3, 0);

    // Reset while waiting on a load
    clear_prog(ALU);
    prog[0] = LD;
    step(0, 1);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    chk("s6_idle_pcinit", pc_init_o, 0);

    // Random programs with occasional restarts and resets
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 64; i++) begin
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) prog[i] = {1'b1, 3'($urandom_range(0, 7))};
        else if (k <= 2) prog[i] = {2'b01, 1'b1, 1'($urandom_range(0, 1))};
        else prog[i] = {2'b00, 2'($urandom_range(0, 3))};
      end
      step(0, 1);
      for (int c = 0; c < 14; c++) begin
        int unsigned p;
        p = $urandom_range(0, 99);
        step(p < 3, (p >= 3) && (p < 7));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Multi-cycle run controller for the 9-bit single-issue core. It owns the Start/Ack handshake and initialises the program counter. It gates the PC advance, register-file write and data-memory write enables per instruction, and inserts one stall cycle on loads to cover the synchronous data-memory read. It also keeps cycle and retired-instruction counters, plus a watchdog that forces completion on runaway programs. It sits between TopLevel's Start/Ack pins and the InstFetch/RegFile/DataMem enables; the Ctrl decoder supplies its per-instruction decode inputs.

## Interface
- MAX_CYCLES, 16'hFFFF, watchdog limit on run cycles; reaching it ends the run with Timeout=1
- Clk  input  1  clock, posedge only
- Reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Start  input  1  level; high = hold program in init, falling edge (observed as low in INIT) starts run
- Halt  input  1  decoded halt instruction (all-ones opcode) for current PC
- DecLoad  input  1  current instruction is a load
- DecRegWr  input  1  current instruction writes the register file
- DecMemWr  input  1  current instruction writes data memory
- PcInit  output  1  force PC to 0 this cycle
- PcEn  output  1  advance/branch PC at this edge
- RegWrEn  output  1  gated register-file write enable
- MemWrEn  output  1  gated data-memory write enable
- LoadSel  output  1  register write data selects memory read data
- Ack  output  1  run complete (registered)
- Timeout  output  1  run ended by watchdog (registered)
- CycleCt  output  16  cycles spent in EXEC+LDWAIT this run
- InstCt  output  16  instructions retired this run (halt excluded)

## Operation
- States: IDLE, INIT, EXEC, LDWAIT, DONE. Reset -> IDLE, Ack=0, Timeout=0, CycleCt=0, InstCt=0.
- Start=1 in any state -> INIT next edge; counters and Timeout cleared, Ack=0. Reset has priority over Start.
- INIT: PcInit=1, all other enables 0. Stay while Start=1; Start=0 -> EXEC.
- EXEC, in priority order:
  - Halt=1 -> DONE; PcEn=0, no writes, InstCt unchanged.
  - Else DecLoad=1 -> LDWAIT; PcEn=0, RegWrEn=0, MemWrEn=0 (address phase).
  - Else PcEn=1, RegWrEn=DecRegWr, MemWrEn=DecMemWr, InstCt+1; stay in EXEC.
- LDWAIT: LoadSel=1, RegWrEn=1, PcEn=1, InstCt+1 -> EXEC. Decode inputs must be stable (PC frozen).
- DONE: Ack=1, all enables 0, counters frozen; leaves only on Start=1 or Reset.
- IDLE: all outputs 0; Start=1 -> INIT.
- CycleCt increments on every edge in EXEC or LDWAIT. If CycleCt+1 == MAX_CYCLES at that edge, go to DONE with Timeout=1, overriding the EXEC/LDWAIT transition; the instruction in flight still retires normally that cycle. Counters never wrap.
- Outputs PcInit/PcEn/RegWrEn/MemWrEn/LoadSel are combinational from state and decode inputs. Ack/Timeout/counters are registered.

## Timing
- Non-load instruction: 1 cycle. Load: 2 cycles (EXEC + LDWAIT). Halt: 1 EXEC cycle, then Ack rises the next edge.
- First EXEC cycle occurs the edge after Start is sampled low in INIT; PC is 0 there because PcInit was held during INIT.
- Start high mid-EXEC/LDWAIT aborts with no write that cycle? No: the write for that cycle's EXEC still issues (enables are combinational on current state); INIT follows the next edge.
- Reset mid-LDWAIT: no register write at that edge; IDLE with all outputs 0 next cycle.
- Halt and DecLoad both high: Halt wins.
- Watchdog and Halt at the same edge: DONE with Timeout=1.

## Test plan
- Reset asserted 2 cycles -> state IDLE, Ack=0, Timeout=0, CycleCt=0, InstCt=0, all enables 0.
- Start high 1 cycle, then program ALU, ALU, ALU, Halt -> PcInit=1 in INIT; PcEn high 3 consecutive cycles; Ack=1 the edge after Halt; CycleCt=4, InstCt=3, Timeout=0.
- Program Load, ALU, Halt -> first EXEC cycle PcEn=0 and RegWrEn=0; LDWAIT has LoadSel=1, RegWrEn=1, PcEn=1; CycleCt=4, InstCt=2.
- MAX_CYCLES=8, program of 20 ALU ops with no halt -> Ack=1 and Timeout=1 after exactly 8 run cycles; CycleCt=8, InstCt=8.
- Start pulsed high after 5 EXEC cycles -> INIT next edge; counters=0; PC re-initialised; rerun gives the same counts as scenario 2.
- Reset asserted during LDWAIT -> no RegWrEn at that edge; IDLE with all outputs 0 next cycle.
